// File: rtl/nn_result_stream.sv
// nn_result_stream
// Classifies each incoming neuron pair (class = neuron1 > neuron0, signed),
// buffers {class, neuron1, neuron0} in a small circular FIFO and emits the
// results as an AXI-stream master with tlast on the final result of a frame.
// A result offered while the buffer is full is dropped and latches o_overflow.
// Optional feature: define NN_RESULT_STATS_EN to add o_class1_count, a
// wrapping count of popped results whose class bit is 1.
module nn_result_stream #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int FRAME_RESULTS    = 16
) (
    input  logic                                          axi_clk,
    input  logic                                          axi_reset_n,
    input  logic                                          i_data_valid,
    input  logic [2*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]  i_data,
    output logic                                          i_data_ready,
    output logic                                          o_data_valid,
    output logic [31:0]                                   o_data,
    output logic                                          o_last,
    input  logic                                          o_data_ready,
`ifdef NN_RESULT_STATS_EN
    output logic [15:0]                                   o_class1_count,
`endif
    output logic                                          o_overflow
);

    localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int EW = 2 * W + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = (FRAME_RESULTS > 1) ? $clog2(FRAME_RESULTS) : 1;

    localparam logic [AW:0]   DEPTH_C      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FRAME_LAST_C = FW'(FRAME_RESULTS - 1);

    // Builds a buffer entry: class bit on top, the raw neuron pair below it.
    // Ties resolve to class 0 because the comparison is strict.
    function automatic logic [EW-1:0] pack_result(input logic [2*W-1:0] pair);
        logic signed [W-1:0] n0;
        logic signed [W-1:0] n1;
        logic                cls;
        n0  = signed'(pair[W-1:0]);
        n1  = signed'(pair[2*W-1:W]);
        cls = (n1 > n0);
        return {cls, pair};
    endfunction

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          overflow_q, overflow_d;
`ifdef NN_RESULT_STATS_EN
    logic [15:0]   class1_q, class1_d;
`endif

    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] head;

    // Next-state logic: pointers, occupancy, frame position, overflow flag and
    // the buffer write; readiness never depends on a same-cycle pop.
    always_comb begin
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
        wr_en      = i_data_valid && !full;
        rd_en      = !empty && o_data_ready;
        head       = mem_q[rd_ptr_q];

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        frame_d    = frame_q;
        overflow_d = overflow_q | (i_data_valid & full);
        mem_d      = mem_q;
`ifdef NN_RESULT_STATS_EN
        class1_d   = class1_q;
`endif

        if (wr_en) begin
            mem_d[wr_ptr_q] = pack_result(i_data);
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            frame_d  = (frame_q == FRAME_LAST_C) ? '0 : frame_q + FW'(1);
`ifdef NN_RESULT_STATS_EN
            if (head[EW-1]) begin
                class1_d = class1_q + 16'd1;
            end
`endif
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared immediately by reset, independent of the clock.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            frame_q    <= '0;
            overflow_q <= 1'b0;
`ifdef NN_RESULT_STATS_EN
            class1_q   <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            frame_q    <= frame_d;
            overflow_q <= overflow_d;
`ifdef NN_RESULT_STATS_EN
            class1_q   <= class1_d;
`endif
        end
    end

    // Buffer storage: data only, its contents are meaningless while empty.
    always_ff @(posedge axi_clk) begin
        mem_q <= mem_d;
    end

    // The head entry is shown only while valid, so o_data reads zero in reset.
    assign i_data_ready = !full;
    assign o_data_valid = !empty;
    assign o_data       = o_data_valid ? 32'(head) : 32'd0;
    assign o_last       = o_data_valid && (frame_q == FRAME_LAST_C);
    assign o_overflow   = overflow_q;
`ifdef NN_RESULT_STATS_EN
    assign o_class1_count = class1_q;
`endif

endmodule

// File: doc/nn_result_stream.md
NN_RESULT_STREAM -- requirements
Module: nn_result_stream

Interface
REQ-001 SHALL have parameter INTEGER_BITS, default 9, integer bits of one neuron value.
REQ-002 SHALL have parameter FIXED_POINT_BITS, default 4, fractional bits of one neuron value.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of two, ≥2).
REQ-004 SHALL have parameter FRAME_RESULTS, default 16, results per frame; o_last marks the final result of each frame.
REQ-005 SHALL define W = INTEGER_BITS+FIXED_POINT_BITS; requires 2W+1 ≤ 32.
REQ-006 axi_clk  input  1  single clock; all logic on its rising edge.
REQ-007 axi_reset_n  input  1  asynchronous, active-low reset.
REQ-008 i_data_valid  input  1  neuron pair valid this cycle.
REQ-009 i_data  input  2W  signed two's-complement neurons: [W-1:0] neuron0, [2W-1:W] neuron1.
REQ-010 i_data_ready  output  1  high when the buffer can accept a result.
REQ-011 o_data_valid  output  1  AXI-stream master tvalid.
REQ-012 o_data  output  32  {zero pad, class, neuron1, neuron0}; class at bit 2W.
REQ-013 o_last  output  1  tlast, high with the FRAME_RESULTS-th result of each frame.
REQ-014 o_data_ready  input  1  AXI-stream master tready.
REQ-015 o_overflow  output  1  sticky: a result was dropped.

Function
REQ-016 SHALL write a result when i_data_valid && i_data_ready; i_data_ready = !full, regardless of a same-cycle read.
REQ-017 SHALL compute class = 1 when neuron1 > neuron0 (signed), else 0; ties give class 0.
REQ-018 SHALL store {class, neuron1, neuron0} in a FIFO_DEPTH-entry circular buffer with wrapping read/write pointers.
REQ-019 SHALL present the head entry on o_data with o_data_valid high while the buffer is non-empty; a written result appears on the cycle after the write (latency 1).
REQ-020 SHALL pop the head on o_data_valid && o_data_ready.
REQ-021 SHALL hold o_data, o_last and o_data_valid stable while o_data_valid && !o_data_ready.
REQ-022 Simultaneous write and pop when not full and not empty SHALL leave occupancy unchanged.
REQ-023 A write into an empty buffer with o_data_ready high SHALL NOT bypass; the result appears next cycle.
REQ-024 SHALL keep a frame counter 0..FRAME_RESULTS-1, incremented on each pop and wrapping to 0 after FRAME_RESULTS-1; o_last = o_data_valid && (counter == FRAME_RESULTS-1).
REQ-025 i_data_valid while full SHALL drop the result, set o_overflow and leave buffer contents unchanged.
REQ-026 o_overflow SHALL stay set until reset.
REQ-027 Padding bits of o_data above bit 2W SHALL be 0.

Reset
REQ-028 Assertion of axi_reset_n low SHALL immediately clear pointers, occupancy, frame counter and o_overflow, independent of the clock.
REQ-029 During reset: o_data_valid=0, o_last=0, o_overflow=0, o_data=0 and i_data_ready=1 (buffer empty).
REQ-030 Reset mid-frame SHALL discard buffered results; the first result after reset starts a new frame.
REQ-031 Release SHALL be honoured on the first rising edge after deassertion; no further state carries over.

Configuration
REQ-032 Macro NN_RESULT_STATS_EN: when defined, SHALL add output o_class1_count (16 bits) counting popped results with class 1, wrapping at 65535→0, reset 0.
REQ-033 Without NN_RESULT_STATS_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 W=13: write neuron0=0x0010, neuron1=0x0020, o_data_ready=1 -> next cycle o_data_valid=1, o_data={5'b0,1'b1,13'h0020,13'h0010}, popped that cycle.
REQ-035 Equal neurons 0x1FF0/0x1FF0 (negative) -> class 0; neuron0=0x1FF0, neuron1=0x0001 -> class 1.
REQ-036 o_data_ready=0, write 5 results with FIFO_DEPTH=4 -> i_data_ready falls after the 4th write, 5th dropped, o_overflow=1, o_data stays on result 1; then ready=1 -> results 1-4 in order.
REQ-037 Stream 33 results with ready=1, FRAME_RESULTS=16 -> o_last high on pops 16 and 32 only.
REQ-038 Assert axi_reset_n low with 3 buffered results mid-frame -> o_data_valid=0 without waiting for a clock edge; after release, the next result's frame position is 1.
REQ-039 With NN_RESULT_STATS_EN: pop 3 class-1 and 2 class-0 results -> o_class1_count=3.
